// File: rtl/reg_status_file.sv
// Architectural register file plus Qi rename table for the Tomasulo core.
// Answers operand lookups with same-cycle CDB bypass, renames on issue, retires on CDB.
module reg_status_file #(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 16,
  parameter int unsigned TW   = 3
) (
  input  logic                       CLK,
  input  logic                       CLR,
  input  logic [$clog2(NREG)-1:0]    numR0,
  input  logic [$clog2(NREG)-1:0]    numR1,
  output logic [TW-1:0]              depR0,
  output logic [W-1:0]               dataR0,
  output logic [TW-1:0]              depR1,
  output logic [W-1:0]               dataR1,
  input  logic                       issue,
  input  logic [$clog2(NREG)-1:0]    issueRd,
  input  logic [TW-1:0]              issueTag,
  input  logic                       CDBvalid,
  input  logic [TW-1:0]              CDBtag,
  input  logic [W-1:0]               CDB,
  input  logic                       wrEn,
  input  logic [$clog2(NREG)-1:0]    wrAddr,
  input  logic [W-1:0]               wrData,
  input  logic                       flush,
  output logic [$clog2(NREG+1)-1:0]  pending
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned PW = $clog2(NREG + 1);

  logic [NREG-1:0][W-1:0]  r_q, r_d;
  logic [NREG-1:0][TW-1:0] qi_q, qi_d;
  logic [PW-1:0]           pending_d;
  logic                    cdb_hit;

  // Tag 0 means "no dependency", so it never matches on the CDB.
  assign cdb_hit = CDBvalid && (CDBtag != '0);

  // Per-register next state; later assignments win: flush > wrEn > issue > retire.
  always_comb begin
    r_d       = r_q;
    qi_d      = qi_q;
    pending_d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (cdb_hit && (qi_q[i] == CDBtag)) begin
        r_d[i]  = CDB;
        qi_d[i] = '0;
      end
      if (issue && (issueTag != '0) && (issueRd == AW'(i))) begin
        qi_d[i] = issueTag;
      end
      if (wrEn && (wrAddr == AW'(i))) begin
        r_d[i]  = wrData;
        qi_d[i] = '0;
      end
      if (flush) begin
        qi_d[i] = '0;
      end
      if (qi_d[i] != '0) begin
        pending_d = pending_d + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_q     <= '0;
      qi_q    <= '0;
      pending <= '0;
    end else begin
      r_q     <= r_d;
      qi_q    <= qi_d;
      pending <= pending_d;
    end
  end

  // Operand lookup: current state, overridden by a matching CDB broadcast this cycle.
  always_comb begin
    depR0  = qi_q[numR0];
    dataR0 = r_q[numR0];
    if (cdb_hit && (qi_q[numR0] == CDBtag)) begin
      depR0  = '0;
      dataR0 = CDB;
    end
    depR1  = qi_q[numR1];
    dataR1 = r_q[numR1];
    if (cdb_hit && (qi_q[numR1] == CDBtag)) begin
      depR1  = '0;
      dataR1 = CDB;
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename, retire, bypass, priority, flush and reset.
module tb_reg_status_file;

  logic        CLK, CLR;
  logic [2:0]  numR0, numR1, issueRd, wrAddr;
  logic [2:0]  depR0, depR1, issueTag, CDBtag;
  logic [15:0] dataR0, dataR1, CDB, wrData;
  logic        issue, CDBvalid, wrEn, flush;
  logic [3:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;

  reg_status_file dut (
    .CLK(CLK), .CLR(CLR),
    .numR0(numR0), .numR1(numR1),
    .depR0(depR0), .dataR0(dataR0), .depR1(depR1), .dataR1(dataR1),
    .issue(issue), .issueRd(issueRd), .issueTag(issueTag),
    .CDBvalid(CDBvalid), .CDBtag(CDBtag), .CDB(CDB),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .flush(flush), .pending(pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    issue = 0; issueRd = 0; issueTag = 0;
    CDBvalid = 0; CDBtag = 0; CDB = 0;
    wrEn = 0; wrAddr = 0; wrData = 0; flush = 0;
  endtask

  task automatic test_reset();
    CLR = 0; idle(); numR0 = 3; numR1 = 7;
    #12;
    n_tests++;
    if ({depR0, dataR0, depR1, dataR1, pending} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset: dep0=%0d data0=%h dep1=%0d data1=%h pending=%0d, want all 0",
               depR0, dataR0, depR1, dataR1, pending);
    end
    @(negedge CLK); CLR = 1;
    tick();
  endtask

  task automatic test_write();
    wrEn = 1; wrAddr = 3; wrData = 16'h1234; numR0 = 3;
    #1;
    n_tests++;
    if (dataR0 !== 16'h0000) begin
      n_fail++; $display("FAIL wr_same_cycle: data0=%h want 0000", dataR0);
    end
    tick(); idle();
    #1;
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd0, 16'h1234, 4'd0}) begin
      n_fail++;
      $display("FAIL wr: dep0=%0d data0=%h pending=%0d want 0/1234/0", depR0, dataR0, pending);
    end
  endtask

  task automatic test_issue();
    issue = 1; issueRd = 3; issueTag = 5; numR0 = 3;
    #1;
    n_tests++;
    if (depR0 !== 3'd0) begin
      n_fail++; $display("FAIL issue_same_cycle: dep0=%0d want 0", depR0);
    end
    tick(); idle();
    #1;
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd5, 16'h1234, 4'd1}) begin
      n_fail++;
      $display("FAIL issue: dep0=%0d data0=%h pending=%0d want 5/1234/1", depR0, dataR0, pending);
    end
  endtask

  task automatic test_cdb_bypass();
    CDBvalid = 1; CDBtag = 5; CDB = 16'hBEEF; numR1 = 3; numR0 = 2;
    #1;
    n_tests++;
    if ({depR1, dataR1} !== {3'd0, 16'hBEEF}) begin
      n_fail++; $display("FAIL bypass: dep1=%0d data1=%h want 0/beef", depR1, dataR1);
    end
    n_tests++;
    if ({depR0, dataR0} !== {3'd0, 16'h0000}) begin
      n_fail++; $display("FAIL bypass_other: dep0=%0d data0=%h want 0/0000", depR0, dataR0);
    end
    tick(); idle();
    #1;
    n_tests++;
    if ({depR1, dataR1, pending} !== {3'd0, 16'hBEEF, 4'd0}) begin
      n_fail++;
      $display("FAIL retire: dep1=%0d data1=%h pending=%0d want 0/beef/0", depR1, dataR1, pending);
    end
  endtask

  task automatic test_multi_retire();
    issue = 1; issueRd = 2; issueTag = 4;
    tick();
    issueRd = 6;
    tick(); idle();
    n_tests++;
    if (pending !== 4'd2) begin
      n_fail++; $display("FAIL tag_reuse_pending: pending=%0d want 2", pending);
    end
    CDBvalid = 1; CDBtag = 4; CDB = 16'h0042;
    issue = 1; issueRd = 6; issueTag = 1;
    tick(); idle();
    numR0 = 2; numR1 = 6;
    #1;
    n_tests++;
    if ({depR0, dataR0, depR1, dataR1, pending} !== {3'd0, 16'h0042, 3'd1, 16'h0042, 4'd1}) begin
      n_fail++;
      $display("FAIL multi_retire: dep0=%0d data0=%h dep1=%0d data1=%h pending=%0d want 0/0042/1/0042/1",
               depR0, dataR0, depR1, dataR1, pending);
    end
    CDBvalid = 1; CDBtag = 1; CDB = 16'h0077;
    tick(); idle();
    #1;
    n_tests++;
    if ({depR1, dataR1, pending} !== {3'd0, 16'h0077, 4'd0}) begin
      n_fail++;
      $display("FAIL retire_r6: dep1=%0d data1=%h pending=%0d want 0/0077/0", depR1, dataR1, pending);
    end
  endtask

  task automatic test_flush();
    issue = 1; issueRd = 1; issueTag = 2;
    tick();
    issueRd = 7; issueTag = 3;
    tick(); idle();
    // CDB tag 0 must not touch registers whose Qi is 0.
    CDBvalid = 1; CDBtag = 0; CDB = 16'hDEAD;
    tick(); idle();
    numR0 = 3; numR1 = 1;
    #1;
    n_tests++;
    if ({dataR0, depR1, pending} !== {16'hBEEF, 3'd2, 4'd2}) begin
      n_fail++;
      $display("FAIL cdb_tag0: data0=%h dep1=%0d pending=%0d want beef/2/2", dataR0, depR1, pending);
    end
    flush = 1; CDBvalid = 1; CDBtag = 3; CDB = 16'h3333;
    issue = 1; issueRd = 5; issueTag = 6;
    tick(); idle();
    numR0 = 7; numR1 = 5;
    #1;
    n_tests++;
    if ({depR0, dataR0, depR1, dataR1, pending} !== {3'd0, 16'h3333, 3'd0, 16'h0000, 4'd0}) begin
      n_fail++;
      $display("FAIL flush: dep0=%0d data0=%h dep1=%0d data1=%h pending=%0d want 0/3333/0/0000/0",
               depR0, dataR0, depR1, dataR1, pending);
    end
    numR0 = 1;
    #1;
    n_tests++;
    if ({depR0, dataR0} !== {3'd0, 16'h0000}) begin
      n_fail++; $display("FAIL flush_r1: dep0=%0d data0=%h want 0/0000", depR0, dataR0);
    end
  endtask

  task automatic test_priority();
    wrEn = 1; wrAddr = 4; wrData = 16'h00FF;
    issue = 1; issueRd = 4; issueTag = 7;
    tick(); idle();
    numR0 = 4;
    #1;
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd0, 16'h00FF, 4'd0}) begin
      n_fail++;
      $display("FAIL wr_over_issue: dep0=%0d data0=%h pending=%0d want 0/00ff/0", depR0, dataR0, pending);
    end
    issue = 1; issueRd = 4; issueTag = 0;
    tick(); idle();
    n_tests++;
    if ({depR0, pending} !== {3'd0, 4'd0}) begin
      n_fail++; $display("FAIL issue_tag0: dep0=%0d pending=%0d want 0/0", depR0, pending);
    end
  endtask

  task automatic test_async_reset();
    issue = 1; issueRd = 4; issueTag = 6;
    tick(); idle();
    numR0 = 4;
    #1;
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd6, 16'h00FF, 4'd1}) begin
      n_fail++;
      $display("FAIL pre_reset: dep0=%0d data0=%h pending=%0d want 6/00ff/1", depR0, dataR0, pending);
    end
    #1;
    CLR = 0;
    #1;
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd0, 16'h0000, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset: dep0=%0d data0=%h pending=%0d want 0/0000/0", depR0, dataR0, pending);
    end
    issue = 1; issueRd = 4; issueTag = 6; wrEn = 1; wrAddr = 4; wrData = 16'hAAAA;
    tick();
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd0, 16'h0000, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_held: dep0=%0d data0=%h pending=%0d want 0/0000/0", depR0, dataR0, pending);
    end
    idle();
    #2;
    CLR = 1;
    tick();
    n_tests++;
    if ({depR0, dataR0, pending} !== {3'd0, 16'h0000, 4'd0}) begin
      n_fail++;
      $display("FAIL post_reset: dep0=%0d data0=%h pending=%0d want 0/0000/0", depR0, dataR0, pending);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_issue();
    test_cdb_bypass();
    test_multi_retire();
    test_flush();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
